// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_INC           = XLEN'(4);
  localparam logic [ILEN-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry pc+instruction holding register, used as the stall buffer.
module fetch_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] insn_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] insn_o
);

  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] insn_q;

  // Clear has priority so a redirect always discards a pending capture.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      pc_q   <= '0;
      insn_q <= '0;
    end else if (load_i) begin
      pc_q   <= pc_i;
      insn_q <= insn_i;
    end
  end

  assign pc_o   = pc_q;
  assign insn_o = insn_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs a single-outstanding imem handshake and
// drives the IF/ID register inputs and write/flush controls.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [ILEN-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [XLEN-1:0] address_out,
  output logic [ILEN-1:0] instruction_out,
  output logic            IF_ID_Write,
  output logic            IF_ID_Flush
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] hold_pc;
  logic [ILEN-1:0] hold_insn;
  logic            accept;
  logic            hold_load;
  logic            hold_clear;

  assign imem_req  = !reset && (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  assign hold_load  = !reset && !branch_taken && (state_q == ST_WAIT) && imem_rvalid && stall;
  assign hold_clear = branch_taken;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (req_pc_q),
    .insn_i  (imem_rdata),
    .pc_o    (hold_pc),
    .insn_o  (hold_insn)
  );

  // IF/ID inputs: delivered word, held word, or a bubble at the current PC.
  always_comb begin
    address_out     = pc_q;
    instruction_out = NOP_INSN;
    IF_ID_Write     = 1'b0;
    IF_ID_Flush     = 1'b0;
    if (reset) begin
      address_out     = '0;
      instruction_out = '0;
      IF_ID_Flush     = 1'b1;
    end else if (branch_taken) begin
      IF_ID_Flush = 1'b1;
    end else if (!stall) begin
      IF_ID_Write = 1'b1;
      if (state_q == ST_WAIT && imem_rvalid) begin
        address_out     = req_pc_q;
        instruction_out = imem_rdata;
      end else if (state_q == ST_HOLD) begin
        address_out     = hold_pc;
        instruction_out = hold_insn;
      end
    end
  end

  // Fetch FSM; a redirect overrides stall and every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (branch_taken) begin
      pc_q <= branch_target;
      case (state_q)
        ST_FETCH: state_q <= accept ? ST_DROP : ST_FETCH;
        ST_WAIT:  state_q <= imem_rvalid ? ST_FETCH : ST_DROP;
        ST_DROP:  state_q <= imem_rvalid ? ST_FETCH : ST_DROP;
        default:  state_q <= ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            req_pc_q <= pc_q;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            pc_q    <= req_pc_q + PC_INC;
            state_q <= stall ? ST_HOLD : ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!stall) state_q <= ST_FETCH;
        end
        default: begin
          if (imem_rvalid) state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [63:0] imem_addr, address_out;
  logic [31:0] imem_rdata, instruction_out;
  logic        IF_ID_Write, IF_ID_Flush;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit #(.RESET_PC(64'h1000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .address_out     (address_out),
    .instruction_out (instruction_out),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic rst, input logic stl, input logic br, input logic [63:0] tgt,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 64'h0, 1, 0, 32'h0);
    drive(1, 0, 0, 64'h0, 1, 1, 32'hFFFF_FFFF);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0h want 0", imem_req); end
    n_cmp++; if (IF_ID_Flush !== 1'b1) begin n_err++; $display("FAIL rst_flush got %0h want 1", IF_ID_Flush); end
    n_cmp++; if (IF_ID_Write !== 1'b0) begin n_err++; $display("FAIL rst_write got %0h want 0", IF_ID_Write); end
    n_cmp++; if (address_out !== 64'h0 || instruction_out !== 32'h0) begin
      n_err++; $display("FAIL rst_ifid got %0h/%0h want 0/0", address_out, instruction_out); end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      n_err++; $display("FAIL first_req got %0h@%0h want 1@1000", imem_req, imem_addr); end
    n_cmp++; if (IF_ID_Write !== 1'b1 || instruction_out !== NOP || address_out !== 64'h1000 || IF_ID_Flush !== 1'b0) begin
      n_err++; $display("FAIL first_bubble got w%0h f%0h %0h/%0h want w1 f0 1000/13", IF_ID_Write, IF_ID_Flush, address_out, instruction_out); end
  endtask

  task automatic test_fetch();
    drive(0, 0, 0, 64'h0, 0, 1, 32'h0050_0093);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL wait_req got %0h want 0", imem_req); end
    n_cmp++; if (address_out !== 64'h1000 || instruction_out !== 32'h0050_0093 || IF_ID_Write !== 1'b1) begin
      n_err++; $display("FAIL deliver got %0h/%0h w%0h want 1000/00500093 w1", address_out, instruction_out, IF_ID_Write); end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1004) begin
      n_err++; $display("FAIL next_addr got %0h@%0h want 1@1004", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    drive(0, 1, 0, 64'h0, 0, 1, 32'h00A0_0113);
    n_cmp++; if (IF_ID_Write !== 1'b0 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_rv got w%0h r%0h want w0 r0", IF_ID_Write, imem_req); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 64'h0, 1, 0, 32'h0);
      n_cmp++; if (IF_ID_Write !== 1'b0 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got w%0h r%0h want w0 r0", i, IF_ID_Write, imem_req); end
    end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (address_out !== 64'h1004 || instruction_out !== 32'h00A0_0113 || IF_ID_Write !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL unstall got %0h/%0h w%0h r%0h want 1004/00a00113 w1 r0", address_out, instruction_out, IF_ID_Write, imem_req); end
    drive(0, 0, 0, 64'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1008) begin
      n_err++; $display("FAIL after_hold got %0h@%0h want 1@1008", imem_req, imem_addr); end
  endtask

  task automatic test_ready_low();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 64'h0, 0, 0, 32'h0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1008 || IF_ID_Write !== 1'b1 ||
                   instruction_out !== NOP || address_out !== 64'h1008) begin
        n_err++; $display("FAIL notready%0d got r%0h@%0h w%0h %0h/%0h want r1@1008 w1 1008/13",
                          i, imem_req, imem_addr, IF_ID_Write, address_out, instruction_out); end
    end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
  endtask

  task automatic test_branch_wait();
    drive(0, 0, 1, 64'h2000, 0, 0, 32'h0);
    n_cmp++; if (IF_ID_Flush !== 1'b1 || IF_ID_Write !== 1'b0) begin
      n_err++; $display("FAIL br_wait got f%0h w%0h want f1 w0", IF_ID_Flush, IF_ID_Write); end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (IF_ID_Flush !== 1'b0 || imem_req !== 1'b0 || address_out !== 64'h2000 || instruction_out !== NOP) begin
      n_err++; $display("FAIL drop_idle got f%0h r%0h %0h/%0h want f0 r0 2000/13", IF_ID_Flush, imem_req, address_out, instruction_out); end
    drive(0, 0, 0, 64'h0, 1, 1, 32'hDEAD_BEEF);
    n_cmp++; if (instruction_out !== NOP || imem_req !== 1'b0) begin
      n_err++; $display("FAIL drop_rv got %0h r%0h want 13 r0", instruction_out, imem_req); end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      n_err++; $display("FAIL br_refetch got %0h@%0h want 1@2000", imem_req, imem_addr); end
  endtask

  task automatic test_branch_rvalid_stall();
    drive(0, 1, 1, 64'h3000, 0, 1, 32'h1111_1111);
    n_cmp++; if (IF_ID_Flush !== 1'b1 || IF_ID_Write !== 1'b0) begin
      n_err++; $display("FAIL br_rv got f%0h w%0h want f1 w0", IF_ID_Flush, IF_ID_Write); end
    drive(0, 0, 0, 64'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin
      n_err++; $display("FAIL br_rv_req got %0h@%0h want 1@3000", imem_req, imem_addr); end
    n_cmp++; if (instruction_out !== NOP || address_out !== 64'h3000 || IF_ID_Write !== 1'b1) begin
      n_err++; $display("FAIL br_rv_nohold got %0h/%0h w%0h want 3000/13 w1", address_out, instruction_out, IF_ID_Write); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h0);
    n_cmp++; if (IF_ID_Flush !== 1'b1 || IF_ID_Write !== 1'b0 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL br_fetch got f%0h w%0h r%0h want f1 w0 r1", IF_ID_Flush, IF_ID_Write, imem_req); end
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++; $display("FAIL wrap_addr got %0h want fffffffffffffffc", imem_addr); end
    drive(0, 0, 0, 64'h0, 0, 1, 32'h0010_0073);
    n_cmp++; if (address_out !== 64'hFFFF_FFFF_FFFF_FFFC || instruction_out !== 32'h0010_0073) begin
      n_err++; $display("FAIL wrap_deliver got %0h/%0h want fffffffffffffffc/00100073", address_out, instruction_out); end
    drive(0, 0, 0, 64'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL wrap_next got %0h@%0h want 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    drive(1, 0, 0, 64'h0, 0, 0, 32'h0);
    n_cmp++; if (IF_ID_Flush !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL mid_rst got f%0h r%0h want f1 r0", IF_ID_Flush, imem_req); end
    drive(0, 0, 0, 64'h0, 0, 1, 32'h0BAD_0BAD);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000 || instruction_out !== NOP || address_out !== 64'h1000) begin
      n_err++; $display("FAIL late_rv got r%0h@%0h %0h/%0h want r1@1000 1000/13", imem_req, imem_addr, address_out, instruction_out); end
    drive(0, 0, 0, 64'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      n_err++; $display("FAIL late_rv_ign got %0h@%0h want 1@1000", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_fetch();
    test_stall();
    test_ready_low();
    test_branch_wait();
    drive(0, 0, 0, 64'h0, 1, 0, 32'h0);
    test_branch_rvalid_stall();
    test_wrap();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that produces the PC and instruction word written into the IF/ID pipeline register, and the IF_ID_Write / IF_ID_Flush controls that register consumes. It owns the PC, runs a single-outstanding request/response handshake with instruction memory, and buffers one fetched word while the hazard unit stalls. On a taken branch it redirects the PC, flushes IF/ID and drops any in-flight fetch.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NOP_INSN, 32'h00000013, bubble word (addi x0,x0,0) presented when no instruction is available

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
stall  input  1  hazard unit: hold IF/ID contents
branch_taken  input  1  EX-stage redirect, single-cycle pulse
branch_target  input  64  redirect PC, valid with branch_taken
imem_req  output  1  fetch request
imem_addr  output  64  fetch address (= PC)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
address_out  output  64  to IF_ID address_in
instruction_out  output  32  to IF_ID instruction_in
IF_ID_Write  output  1  to IF_ID IF_ID_Write
IF_ID_Flush  output  1  to IF_ID IF_ID_Flush

Behaviour:
- Registers: pc, req_pc (PC of outstanding fetch), hold_pc/hold_insn, state in {FETCH, WAIT, DROP, HOLD}. Reset: pc=RESET_PC, state=FETCH, hold regs and req_pc 0.
- While reset high: imem_req=0, IF_ID_Write=0, IF_ID_Flush=1, address_out=0, instruction_out=0.
- IF/ID outputs are combinational; IF/ID registers them on the next edge.
- Memory handshake: request accepted when imem_req && imem_ready. imem_rvalid arrives at least one cycle after acceptance. At most one request outstanding.
- FETCH: imem_req=1, imem_addr=pc. On acceptance: req_pc<=pc, go WAIT. Otherwise stay; an unaccepted request may change address.
- WAIT: imem_req=0. On rvalid with stall=0: address_out=req_pc, instruction_out=imem_rdata, IF_ID_Write=1, pc<=req_pc+4, go FETCH. On rvalid with stall=1: capture into hold regs, pc<=req_pc+4, go HOLD.
- HOLD: imem_req=0. When stall=0: present hold_pc/hold_insn with IF_ID_Write=1, go FETCH.
- DROP: imem_req=0. Discard the next rvalid, then go FETCH.
- Bubble: when stall=0 and no word is being delivered (FETCH, WAIT without rvalid, DROP), present address_out=pc, instruction_out=NOP_INSN, IF_ID_Write=1.
- Stall: when stall=1, IF_ID_Write=0 in every state.
- Branch_taken overrides stall and every state:
  - IF_ID_Flush=1 and IF_ID_Write=0 that cycle.
  - pc<=branch_target.
  - Hold buffer is discarded.
- Next state after branch_taken:
  - FETCH with request accepted that cycle -> DROP.
  - FETCH not accepted -> FETCH.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid same cycle -> data discarded, FETCH.
  - HOLD -> FETCH.
  - DROP without rvalid -> DROP.
  - DROP with rvalid -> FETCH.
- IF_ID_Flush=0 whenever branch_taken=0 and reset=0.
- PC arithmetic is 64-bit modulo: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. No misalignment check.
- Reset mid-fetch: state returns to FETCH; a late rvalid after reset is ignored because FETCH does not consume rvalid.

Decomposition:
- Shared header (`include, guarded define): state encodings, NOP_INSN value, PC increment constant 4.
- One natural sub-module: fetch_hold_buf, the single-entry pc+insn holding register with load/clear, reused for the stall buffer.

Test Plan:
- Reset with RESET_PC=64'h1000; release, imem_ready=1, rvalid 1 cycle later with 32'h00500093 -> imem_addr=0x1000, then address_out=0x1000, instruction_out=0x00500093, IF_ID_Write=1; next imem_addr=0x1004.
- stall=1 on rvalid with 32'h00A00113 at PC 0x1004 -> IF_ID_Write=0 for 3 stall cycles, no imem_req; stall drop -> 0x1004/0x00A00113 presented with Write=1, then fetch 0x1008.
- branch_taken with target 0x2000 while in WAIT; rvalid arrives 2 cycles later -> IF_ID_Flush=1 for one cycle, returned word never reaches instruction_out, next imem_addr=0x2000.
- branch_taken coincident with rvalid and stall=1 -> Flush=1, Write=0, hold empty, next request at branch_target.
- imem_ready held low 4 cycles -> imem_req stays 1 at the same addr, NOP_INSN bubbles with Write=1 each cycle.
- PC 64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=64'h0.
